// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch FSM states and latency-counter sizing for the CPU front end
package cpu_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int MAX_MEM_LAT = 3;
    localparam int LAT_W       = $clog2(MAX_MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle fetch stage that reads memory at pc and hands the word to decode via valid/ready
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              flush,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready
);

    fetch_state_t      state;
    logic [LAT_W-1:0]  lat;
    logic [ADDR_W-1:0] pc_q;

    // pc_q doubles as the last issued address, so the read address stays put outside ISSUE
    assign pc_en       = ir_valid & ir_ready & ~flush & ~rst;
    assign mem_rd_en   = state == ISSUE;
    assign mem_rd_addr = mem_rd_en ? pc : pc_q;

    // fetch FSM: issue, count down the memory latency, capture into ir, hold until decode accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat      <= '0;
            pc_q     <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= fetch_en ? ISSUE : IDLE;
                ISSUE: begin
                    pc_q  <= pc;
                    lat   <= LAT_W'(MEM_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    if (lat == LAT_W'(1)) begin
                        ir       <= mem_rd_data;
                        ir_pc    <= pc_q;
                        ir_valid <= 1'b1;
                        lat      <= '0;
                        state    <= HOLD;
                    end else begin
                        lat <= lat - LAT_W'(1);
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= fetch_en ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multicycle instruction-fetch stage directly downstream of the program counter.
- Reads the current PC, issues a synchronous instruction-memory read, and waits the fixed read latency.
- Latches the returned word into the instruction register and offers it to decode with a valid/ready handshake.
- Pulses pc_en to advance the PC exactly once per instruction accepted by decode; supports flush on branch/jump redirect.

Parameters:
- ADDR_W, 16, instruction address width (matches PC count width)
- DATA_W, 16, instruction word width
- MEM_LAT, 1, instruction-memory read latency in cycles (legal 1..3)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_en  in  1  permission to start new fetches
- pc  in  ADDR_W  current PC count
- pc_en  out  1  advance-PC strobe to program counter
- mem_rd_en  out  1  instruction-memory read request
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data, valid MEM_LAT cycles after request
- flush  in  1  discard in-flight/held instruction (redirect in progress)
- ir  out  DATA_W  instruction register
- ir_pc  out  ADDR_W  address the word in ir was fetched from
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_ready  in  1  decode accepts ir this cycle

Behaviour:
- Reset (rst=1 at edge): state IDLE; ir, ir_pc, lat counter = 0; ir_valid, mem_rd_en = 0. pc_en forced 0 combinationally while rst=1. Applies mid-operation; any in-flight read is dropped.
- States: IDLE, ISSUE, WAIT, HOLD (enum in package).
- IDLE: outputs quiet. fetch_en=1 and flush=0 -> ISSUE.
- ISSUE (1 cycle): mem_rd_en=1, mem_rd_addr=pc; pc_q<=pc; lat counter<=MEM_LAT; -> WAIT.
- mem_rd_en is 1 only in ISSUE; mem_rd_addr=pc in ISSUE, else holds last issued address.
- WAIT: counter decrements each cycle. At the edge ending the MEM_LAT-th cycle after ISSUE: ir<=mem_rd_data, ir_pc<=pc_q, ir_valid<=1, -> HOLD.
- For MEM_LAT=1: ISSUE at cycle n, capture at end of n+1, ir_valid=1 in n+2.
- HOLD: ir, ir_pc stable while ir_valid=1 and ir_ready=0.
- pc_en = ir_valid & ir_ready & ~flush & ~rst (combinational, 1 cycle per accept).
- On accept: ir_valid<=0; next state ISSUE if fetch_en=1, else IDLE. The PC updates on the same edge, so ISSUE reads the new PC.
- Steady throughput: one instruction per MEM_LAT+2 cycles with ir_ready held high.
- fetch_en=0 mid-fetch: the current fetch completes to HOLD and waits for handshake; no new ISSUE after it.
- flush=1 (any state, priority over handshake): pc_en=0; ir_valid<=0; pending read data ignored; state<=IDLE for at least one cycle. IDLE then follows normal rules, so the re-fetch issues no earlier than 2 cycles after the flush edge.
- flush and ir_ready high in the same cycle: flush wins; no accept, no pc_en.
- ir keeps its last value after accept or flush (only ir_valid clears); reset clears it to 0.
- No address arithmetic in this block; PC wrap-around is the program counter's concern. ir_pc is a straight copy.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W/DATA_W defaults
  - fetch_state_t enum (IDLE, ISSUE, WAIT, HOLD)
  - MAX_MEM_LAT=3 constant
  - latency counter width ($clog2(MAX_MEM_LAT+1))
- No sub-module: FSM, latency countdown and IR register are inline in one module.

Test Plan:
- MEM_LAT=1, rst then fetch_en=1, ir_ready=1, mem[0]=16'h1234, pc=0: mem_rd_en at cycle 1 with addr 0; ir=16'h1234, ir_pc=0, ir_valid=1 at cycle 3; pc_en=1 for exactly one cycle at cycle 3.
- Backpressure: ir_ready=0 for 5 cycles in HOLD: ir_valid stays 1, ir/ir_pc unchanged, pc_en=0, mem_rd_en=0. ir_ready=1 -> single pc_en pulse; next ISSUE addresses pc+1.
- MEM_LAT=3, mem[5]=16'hBEEF, pc=5: ir_valid rises exactly 4 cycles after the ISSUE cycle, with ir=16'hBEEF, ir_pc=5.
- flush during WAIT: no ir_valid for that fetch, and pc_en=0. With pc redirected to 16'h0040, the next mem_rd_addr is 16'h0040, issued ≥2 cycles after the flush edge.
- flush and ir_ready both 1 in HOLD: pc_en=0, ir_valid cleared next cycle, state IDLE.
- rst=1 asserted in WAIT and in HOLD: on next edge ir=0, ir_valid=0, mem_rd_en=0, state IDLE; pc_en=0 during the reset cycle; fetch_en=0 afterwards keeps the block idle.
